// File: rtl/mult_pkg.sv
// Shared widths, FSM state type and the accumulator sizing rule for the
// multiply-accumulate stage.
package mult_pkg;

  localparam int X_W = 3;
  localparam int Y_W = 2;
  localparam int P_W = 5;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } mac_state_e;

  // Smallest accumulator that cannot overflow when n full-scale products are summed.
  function automatic int acc_w_min(input int n);
    return P_W + $clog2(n);
  endfunction

endpackage

// File: rtl/mult_accumulator_if.sv
// Operand-in / group-sum-out handshakes of the multiply-accumulate stage.
interface mult_accumulator_if #(
  parameter int ACC_W = 7,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_x;
  logic [1:0]       in_y;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_x, in_y, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_x, in_y, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/multiply.sv
// 3x2 unsigned combinational multiplier built as two gated partial products.
module multiply (
  input  logic [2:0] x,
  input  logic [1:0] y,
  output logic [4:0] Q
);
  logic [4:0] pp0, pp1;

  assign pp0 = {2'b00, x & {3{y[0]}}};
  assign pp1 = {1'b0, x & {3{y[1]}}, 1'b0};
  assign Q   = pp0 + pp1;
endmodule

// File: rtl/mult_accumulator.sv
// Accumulates up to N_TERMS products per group and holds the group sum
// until downstream accepts it.
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 7,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  mult_accumulator_if.slave bus
);

  if (ACC_W < acc_w_min(N_TERMS)) begin : g_acc_w_chk
    $error("ACC_W too narrow for N_TERMS");
  end
  if (CNT_W < $clog2(N_TERMS + 1)) begin : g_cnt_w_chk
    $error("CNT_W too narrow for N_TERMS");
  end

  mac_state_e       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   product;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             close;

  multiply u_multiply (
    .x (bus.in_x),
    .y (bus.in_y),
    .Q (product)
  );

  assign acc_nxt = acc + ACC_W'(product);
  assign cnt_nxt = cnt + CNT_W'(1);
  // in_last and the N_TERMS boundary on one beat collapse into a single close.
  assign close   = bus.in_last || (cnt_nxt == CNT_W'(N_TERMS));

  // Handshake outputs decode the state register only; no input-to-output path.
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCUM;
      acc           <= '0;
      cnt           <= '0;
      bus.out_sum   <= '0;
      bus.out_count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            if (close) begin
              bus.out_sum   <= acc_nxt;
              bus.out_count <= cnt_nxt;
              acc           <= '0;
              cnt           <= '0;
              state         <= DONE;
            end else begin
              acc <= acc_nxt;
              cnt <= cnt_nxt;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_accumulator.sv
// Randomised and directed stimulus against a plain-arithmetic group-sum model;
// a monitor checks each presented result against the expected-result queue.
module tb_mult_accumulator;
  localparam int N  = 4;
  localparam int AW = 7;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_accumulator_if #(.ACC_W(AW), .CNT_W(CW)) bus ();

  mult_accumulator #(.N_TERMS(N), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int sum;
    int cnt;
  } res_t;

  res_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   macc        = 0;
  int   mcnt        = 0;
  bit   exp_done    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: check handshake state, drive inputs, advance the model to
  // what should hold after the coming rising edge.
  task automatic step(input bit v, input int x, input int y, input bit last, input bit ordy);
    @(negedge clk);
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, !exp_done});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_done});
    bus.in_valid  = v;
    bus.in_x      = 3'(x);
    bus.in_y      = 2'(y);
    bus.in_last   = last;
    bus.out_ready = ordy;
    if (!exp_done) begin
      if (v) begin
        macc += x * y;
        mcnt++;
        if (last || mcnt == N) begin
          exp_q.push_back('{sum: macc, cnt: mcnt});
          macc     = 0;
          mcnt     = 0;
          exp_done = 1'b1;
        end
      end
    end else if (ordy) begin
      exp_done = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    macc     = 0;
    mcnt     = 0;
    exp_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
  endtask

  // Monitor: a result sits on the outputs whenever out_valid is high; it is
  // consumed when out_ready is high for the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got sum %0d count %0d, none expected",
                   bus.out_sum, bus.out_count);
        end else begin
          check("out_sum", 32'(bus.out_sum), exp_q[0].sum);
          check("out_count", 32'(bus.out_count), exp_q[0].cnt);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();

    // full group of maximal products -> 84 / 4
    for (int i = 0; i < 4; i++) step(1, 7, 3, 0, 1);
    step(0, 0, 0, 0, 1);

    // early close -> 13 / 2
    step(1, 5, 2, 0, 1);
    step(1, 3, 1, 1, 1);
    step(0, 0, 0, 0, 1);

    // backpressure with offered beats that must not be consumed
    step(1, 1, 2, 0, 1);
    step(1, 2, 2, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1);

    // zeros and gaps -> 3 / 4
    step(1, 0, 3, 0, 1);
    step(0, 5, 3, 1, 1);
    step(0, 7, 2, 1, 1);
    step(1, 7, 0, 0, 1);
    step(1, 1, 1, 0, 1);
    step(1, 2, 1, 0, 1);
    step(0, 0, 0, 0, 1);

    // last on the boundary beat, then a fresh group
    step(1, 1, 1, 0, 1);
    step(1, 2, 1, 0, 1);
    step(1, 3, 1, 0, 1);
    step(1, 4, 1, 1, 1);
    step(1, 5, 1, 1, 1);
    step(1, 6, 2, 1, 1);
    step(0, 0, 0, 0, 1);

    // reset mid-group, then a single-term group -> 1 / 1
    step(1, 6, 3, 0, 1);
    step(1, 6, 3, 0, 1);
    do_reset();
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1);

    // reset while a result is held
    step(1, 3, 3, 1, 0);
    step(0, 0, 0, 0, 0);
    do_reset();

    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
           ($urandom % 5) == 0, ($urandom % 3) != 0);

    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_done); i++) step(0, 0, 0, 0, 1);
    @(negedge clk);
    #2;
    check("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
